// File: rtl/pipe_elastic_reg.sv
// Elastic valid/ready stage register with optional skid entry,
// flush-to-bubble and a saturating idle-bubble counter.
module pipe_elastic_reg #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 8,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bubble,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bubble,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              m_bubble;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              s_bubble;
    logic              in_ready_q;
    logic              fire_in;
    logic              fire_out;

    assign out_valid  = (state != EMPTY);
    assign out_ctrl   = out_valid ? m_ctrl : '0;
    assign out_bubble = out_valid ? m_bubble : 1'b1;
    assign out_data   = m_data;

    // Skid mode breaks the out_ready -> in_ready timing path.
    assign in_ready = SKID_EN ? in_ready_q
                              : ((state == EMPTY) | out_ready);

    assign fire_in  = in_valid & in_ready;
    assign fire_out = out_valid & out_ready;

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (fire_in)
                        state_next = ONE;
                end
                ONE: begin
                    if (fire_in && !fire_out && SKID_EN)
                        state_next = FULL;
                    else if (fire_out && !fire_in)
                        state_next = EMPTY;
                end
                FULL: begin
                    if (fire_out)
                        state_next = ONE;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != FULL);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_ctrl   <= '0;
            m_data   <= '0;
            m_bubble <= 1'b0;
            s_ctrl   <= '0;
            s_data   <= '0;
            s_bubble <= 1'b0;
        end else if (flush) begin
            m_ctrl <= '0;
            s_ctrl <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (fire_in) begin
                        m_ctrl   <= in_ctrl;
                        m_data   <= in_data;
                        m_bubble <= in_bubble;
                    end
                end
                ONE: begin
                    if (fire_in && fire_out) begin
                        m_ctrl   <= in_ctrl;
                        m_data   <= in_data;
                        m_bubble <= in_bubble;
                    end else if (fire_in && SKID_EN) begin
                        s_ctrl   <= in_ctrl;
                        s_data   <= in_data;
                        s_bubble <= in_bubble;
                    end
                end
                FULL: begin
                    if (fire_out) begin
                        m_ctrl   <= s_ctrl;
                        m_data   <= s_data;
                        m_bubble <= s_bubble;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            bubble_count <= '0;
        else if (out_ready && !out_valid
                 && bubble_count != {CNT_W{1'b1}})
            bubble_count <= bubble_count + CNT_W'(1);
    end

endmodule
